// File: rtl/muu_request_widen512.sv
// Widens the 64-bit request stream into 576-bit splitter beats: header/key words travel alone,
// value words are packed eight per beat, and the header length is rewritten as an output-beat count.
module muu_request_widen512 #(
  parameter int unsigned NET_META_WIDTH = 64,
  parameter int unsigned USER_BITS      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [63:0]                 s_axis_tdata,
  input  logic [NET_META_WIDTH-1:0]   s_axis_tuser,
  input  logic [USER_BITS-1:0]        s_axis_tuserid,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [NET_META_WIDTH+511:0] m_axis_tdata,
  output logic [USER_BITS-1:0]        m_axis_tuserid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        err_len
);

  // Opcodes carrying a key word (values mirror muu_ops.vh).
  localparam logic [7:0] OpProposal          = 8'h01;
  localparam logic [7:0] OpWriteReq          = 8'h02;
  localparam logic [7:0] OpReadReq           = 8'h03;
  localparam logic [7:0] OpFlushDatastore    = 8'h04;
  localparam logic [7:0] OpUnversionedWrite  = 8'h05;
  localparam logic [7:0] OpUnversionedDelete = 8'h06;
  localparam logic [7:0] OpReadConditional   = 8'h07;

  typedef enum logic [2:0] {StHdr0, StHdr1, StKey, StPack, StDrain} state_e;

  state_e                    state_q, state_d;
  logic                      key_q;
  logic [15:0]               len_q;
  logic [15:0]               wleft_q;
  logic [2:0]                pos_q;
  logic [511:0]              acc_q;
  logic [NET_META_WIDTH-1:0] meta_q;
  logic [USER_BITS-1:0]      userid_q;

  logic [7:0]                opcode;
  logic [15:0]               hdr_len;
  logic                      hdr_key;
  logic [16:0]               val_words;
  logic [15:0]               hdr_beats;
  logic [15:0]               new_len;
  logic                      last_word;
  logic                      complete;
  logic                      beat_last;
  logic                      mismatch;
  logic                      accept;
  logic [511:0]              payload;
  logic [NET_META_WIDTH-1:0] meta_sel;
  logic [USER_BITS-1:0]      userid_sel;

  // Header length rewrite: key word counts as one beat, values round up to whole beats.
  always_comb begin
    opcode    = s_axis_tdata[31:24];
    hdr_len   = s_axis_tdata[47:32];
    hdr_key   = opcode inside {OpProposal, OpWriteReq, OpReadReq, OpFlushDatastore,
                               OpUnversionedWrite, OpUnversionedDelete, OpReadConditional};
    val_words = (hdr_len > {15'b0, hdr_key}) ? ({1'b0, hdr_len} - {16'b0, hdr_key}) : 17'd0;
    hdr_beats = {15'b0, hdr_key} + 16'((val_words + 17'd7) >> 3);
    new_len   = (hdr_len == 16'd0) ? 16'd0 : hdr_beats;
  end

  always_comb begin
    last_word          = (wleft_q == 16'd1);
    complete           = 1'b0;
    beat_last          = 1'b0;
    mismatch           = 1'b0;
    state_d            = state_q;
    payload            = '0;
    payload[63:0]      = s_axis_tdata;
    unique case (state_q)
      StHdr0: begin
        complete       = 1'b1;
        payload[47:32] = new_len;
        beat_last      = s_axis_tlast;
        mismatch       = s_axis_tlast;
        state_d        = s_axis_tlast ? StHdr0 : StHdr1;
      end
      StHdr1: begin
        complete = 1'b1;
        if (len_q == 16'd0) begin
          beat_last = 1'b1;
          state_d   = StHdr0;
        end else if (s_axis_tlast) begin
          beat_last = 1'b1;
          mismatch  = 1'b1;
          state_d   = StHdr0;
        end else begin
          state_d = key_q ? StKey : StPack;
        end
      end
      StKey, StPack: begin
        if (state_q == StPack) begin
          payload                      = acc_q;
          payload[{pos_q, 6'b0} +: 64] = s_axis_tdata;
          complete = (pos_q == 3'd7) || last_word || s_axis_tlast;
        end else begin
          complete = 1'b1;
        end
        beat_last = last_word || s_axis_tlast;
        mismatch  = last_word != s_axis_tlast;
        if (s_axis_tlast) begin
          state_d = StHdr0;
        end else if (last_word) begin
          state_d = StDrain;
        end else begin
          state_d = StPack;
        end
      end
      StDrain: begin
        if (s_axis_tlast) state_d = StHdr0;
      end
      default: state_d = StHdr0;
    endcase
  end

  // The HDR0 beat carries the metadata being captured on that same word.
  assign meta_sel   = (state_q == StHdr0) ? s_axis_tuser : meta_q;
  assign userid_sel = (state_q == StHdr0) ? s_axis_tuserid : userid_q;

  assign s_axis_tready = (state_q == StDrain) || !complete || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StHdr0;
      key_q          <= 1'b0;
      len_q          <= '0;
      wleft_q        <= '0;
      pos_q          <= '0;
      acc_q          <= '0;
      meta_q         <= '0;
      userid_q       <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tuserid <= '0;
      err_len        <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (accept) begin
        state_q <= state_d;
        err_len <= mismatch;
        if (complete) begin
          m_axis_tvalid  <= 1'b1;
          m_axis_tdata   <= {meta_sel, payload};
          m_axis_tlast   <= beat_last;
          m_axis_tuserid <= userid_sel;
        end
        case (state_q)
          StHdr0: begin
            meta_q   <= s_axis_tuser;
            userid_q <= s_axis_tuserid;
            key_q    <= hdr_key;
            len_q    <= hdr_len;
          end
          StHdr1: begin
            wleft_q <= len_q;
            pos_q   <= '0;
            acc_q   <= '0;
          end
          StKey: wleft_q <= wleft_q - 16'd1;
          StPack: begin
            wleft_q <= wleft_q - 16'd1;
            if (complete) begin
              acc_q <= '0;
              pos_q <= '0;
            end else begin
              acc_q <= payload;
              pos_q <= pos_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muu_request_widen512.sv
// Randomised bench for muu_request_widen512: packets are expanded into expected beats by a
// packet-level reference model and compared against beats collected from the output stream.
module tb_muu_request_widen512;

  localparam logic [7:0] OP_PROPOSAL   = 8'h01;
  localparam logic [7:0] OP_WRITEREQ   = 8'h02;
  localparam logic [7:0] OP_READREQ    = 8'h03;
  localparam logic [7:0] OP_FLUSHDS    = 8'h04;
  localparam logic [7:0] OP_UVWRITE    = 8'h05;
  localparam logic [7:0] OP_UVDELETE   = 8'h06;
  localparam logic [7:0] OP_READCOND   = 8'h07;
  localparam logic [7:0] OP_NOKEY      = 8'h20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  s_axis_tdata = '0;
  logic [63:0]  s_axis_tuser = '0;
  logic [2:0]   s_axis_tuserid = '0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [575:0] m_axis_tdata;
  logic [2:0]   m_axis_tuserid;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         err_len;

  muu_request_widen512 #(
    .NET_META_WIDTH(64),
    .USER_BITS     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tuserid(s_axis_tuserid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuserid(m_axis_tuserid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .err_len       (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] meta;
    logic [2:0]  uid;
    logic        last;
  } word_t;

  typedef struct {
    logic [575:0] data;
    logic [2:0]   uid;
    logic         last;
  } beat_t;

  word_t stim_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    err_cnt = 0;
  int    exp_err = 0;
  int    stab_viol = 0;
  int    ready_pct = 100;

  // Output sink: random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1 m_axis_tready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Output monitor: records transferred beats, err pulses and stall-stability violations.
  initial begin
    bit           stall_prev;
    logic [575:0] prev_data;
    logic         prev_last;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                           m_axis_tlast !== prev_last))
          stab_viol++;
        if (m_axis_tvalid && m_axis_tready) begin
          beat_t b;
          b.data = m_axis_tdata;
          b.uid  = m_axis_tuserid;
          b.last = m_axis_tlast;
          obs_q.push_back(b);
        end
        if (err_len) err_cnt++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_key(input logic [7:0] op);
    case (op)
      OP_PROPOSAL, OP_WRITEREQ, OP_READREQ, OP_FLUSHDS,
      OP_UVWRITE, OP_UVDELETE, OP_READCOND: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push_beat(input logic [511:0] p, input bit last,
                                    input logic [63:0] meta, input logic [2:0] uid);
    beat_t b;
    b.data = {meta, p};
    b.uid  = uid;
    b.last = last;
    exp_q.push_back(b);
  endfunction

  function automatic void clear_scoreboard();
    exp_q.delete();
    obs_q.delete();
    stim_q.delete();
    err_cnt   = 0;
    exp_err   = 0;
    stab_viol = 0;
  endfunction

  // Build an n-word packet with header length len and expand it into the expected beats.
  task automatic build_packet(input logic [7:0] op, input int len, input int n);
    logic [63:0]  w[$];
    logic [63:0]  meta, h, tmp;
    logic [511:0] pay;
    logic [2:0]   uid;
    word_t        wd;
    bit           k;
    int           lp, m, idx, cnt;
    meta = {$urandom, $urandom};
    uid  = 3'($urandom_range(7));
    for (int i = 0; i < n; i++) begin
      tmp = {$urandom, $urandom};
      if (i == 0) begin
        tmp[31:24] = op;
        tmp[47:32] = len[15:0];
      end
      w.push_back(tmp);
      wd.data = tmp;
      wd.last = (i == n - 1);
      wd.meta = (i == 0) ? meta : {$urandom, $urandom};
      wd.uid  = (i == 0) ? uid : 3'($urandom_range(7));
      stim_q.push_back(wd);
    end
    k  = is_key(op);
    lp = (len == 0) ? 0 : int'(k) + (((len > int'(k)) ? len - int'(k) : 0) + 7) / 8;
    h  = w[0];
    h[47:32] = lp[15:0];
    push_beat({448'b0, h}, n == 1, meta, uid);
    if (n == 1) begin
      exp_err++;
      return;
    end
    push_beat({448'b0, w[1]}, (len == 0) || (n == 2), meta, uid);
    if (len == 0) return;
    if (n == 2) begin
      exp_err++;
      return;
    end
    m = (n - 2 < len) ? n - 2 : len;
    if (n - 2 != len) exp_err++;
    idx = 2;
    if (k) begin
      push_beat({448'b0, w[2]}, m == 1, meta, uid);
      idx = 3;
      m--;
    end
    while (m > 0) begin
      cnt = (m < 8) ? m : 8;
      pay = '0;
      for (int j = 0; j < cnt; j++) pay[64*j +: 64] = w[idx + j];
      idx += cnt;
      m   -= cnt;
      push_beat(pay, m == 0, meta, uid);
    end
  endtask

  task automatic drive_all(input int gap_pct);
    word_t wd;
    int    guard;
    while (stim_q.size() > 0) begin
      wd = stim_q.pop_front();
      while (int'($urandom_range(99)) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axis_tvalid  = 1'b1;
      s_axis_tdata   = wd.data;
      s_axis_tuser   = wd.meta;
      s_axis_tuserid = wd.uid;
      s_axis_tlast   = wd.last;
      guard = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        guard++;
        if (guard > 2000) begin
          vectors++;
          miscompares++;
          $display("FAIL input_accept_timeout: tready=%b after %0d cycles, want 1",
                   s_axis_tready, guard);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(output bit ok);
    int g = 0;
    while (obs_q.size() < exp_q.size() && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    ok = (g < 5000);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    if (m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast);
    end
    if (m_axis_tdata !== 576'b0) begin
      miscompares++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata);
    end
    if (err_len !== 1'b0) begin
      miscompares++; $display("FAIL reset_err_len: got %b want 0", err_len);
    end
    if (s_axis_tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_tready: got %b want 1", s_axis_tready);
    end
    apply_reset();
  endtask

  task automatic test_writereq_l17();
    bit    ok;
    beat_t b;
    clear_scoreboard();
    ready_pct = 100;
    build_packet(OP_WRITEREQ, 17, 19);
    drive_all(0);
    wait_outputs(ok);
    vectors++;
    if (!ok || obs_q.size() != 5) begin
      miscompares++; $display("FAIL l17_beat_count: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].uid !== exp_q[i].uid) begin
        miscompares++;
        $display("FAIL l17_beat %0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].data,
                 obs_q[i].last, obs_q[i].uid, exp_q[i].data, exp_q[i].last, exp_q[i].uid);
      end
    end
    if (obs_q.size() > 0) begin
      b = obs_q[0];
      vectors++;
      if (b.data[47:32] !== 16'd3) begin
        miscompares++; $display("FAIL l17_hdr_len: got %0d want 3", b.data[47:32]);
      end
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++; $display("FAIL l17_err_len: got %0d pulses want 0", err_cnt);
    end
  endtask

  task automatic test_writereq_l4();
    bit    ok;
    beat_t b;
    clear_scoreboard();
    ready_pct = 100;
    build_packet(OP_WRITEREQ, 4, 6);
    drive_all(20);
    wait_outputs(ok);
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL l4_beat_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].uid !== exp_q[i].uid) begin
        miscompares++;
        $display("FAIL l4_beat %0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].data,
                 obs_q[i].last, obs_q[i].uid, exp_q[i].data, exp_q[i].last, exp_q[i].uid);
      end
    end
    if (obs_q.size() == 4) begin
      b = obs_q[0];
      vectors++;
      if (b.data[47:32] !== 16'd2) begin
        miscompares++; $display("FAIL l4_hdr_len: got %0d want 2", b.data[47:32]);
      end
      b = obs_q[3];
      vectors++;
      if (b.data[511:192] !== 320'b0 || b.last !== 1'b1) begin
        miscompares++;
        $display("FAIL l4_value_pad: got upper=%h last=%b want 0/1", b.data[511:192], b.last);
      end
    end
  endtask

  task automatic test_zero_len();
    bit    ok;
    beat_t b;
    clear_scoreboard();
    ready_pct = 100;
    build_packet(OP_NOKEY, 0, 2);
    drive_all(0);
    wait_outputs(ok);
    vectors++;
    if (!ok || obs_q.size() != 2) begin
      miscompares++; $display("FAIL zero_len_count: got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        miscompares++;
        $display("FAIL zero_len_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data,
                 obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    if (obs_q.size() == 2) begin
      b = obs_q[0];
      vectors++;
      if (b.data[47:32] !== 16'd0 || b.last !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_len_hdr: got len=%0d last=%b want 0/0", b.data[47:32], b.last);
      end
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++; $display("FAIL zero_len_err: got %0d pulses want 0", err_cnt);
    end
  endtask

  task automatic test_early_tlast();
    bit ok;
    clear_scoreboard();
    ready_pct = 100;
    build_packet(OP_READREQ, 9, 5);
    build_packet(OP_WRITEREQ, 4, 6);
    drive_all(0);
    wait_outputs(ok);
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL early_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].uid !== exp_q[i].uid) begin
        miscompares++;
        $display("FAIL early_beat %0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].data,
                 obs_q[i].last, obs_q[i].uid, exp_q[i].data, exp_q[i].last, exp_q[i].uid);
      end
    end
    if (obs_q.size() > 3) begin
      vectors++;
      if (obs_q[3].last !== 1'b1) begin
        miscompares++; $display("FAIL early_close_last: got %b want 1", obs_q[3].last);
      end
    end
    vectors++;
    if (err_cnt != 1) begin
      miscompares++; $display("FAIL early_err_len: got %0d pulse cycles want 1", err_cnt);
    end
  endtask

  task automatic test_random_stall();
    bit       ok;
    logic [7:0] op;
    int       len, n, r;
    logic [7:0] keyed[7];
    keyed = '{OP_PROPOSAL, OP_WRITEREQ, OP_READREQ, OP_FLUSHDS, OP_UVWRITE, OP_UVDELETE,
              OP_READCOND};
    clear_scoreboard();
    ready_pct = 30;
    for (int p = 0; p < 100; p++) begin
      op = ($urandom_range(1) == 0) ? keyed[$urandom_range(6)] : 8'($urandom);
      len = ($urandom_range(99) < 70) ? int'($urandom_range(20)) : int'($urandom_range(65535));
      r = int'($urandom_range(99));
      if (len == 0) n = int'($urandom_range(2, 1));
      else if (len > 40) n = int'($urandom_range(30, 1));
      else if (r < 70) n = len + 2;
      else if (r < 85) n = int'($urandom_range(len + 1, 1));
      else n = len + 2 + int'($urandom_range(3, 1));
      build_packet(op, len, n);
    end
    drive_all(15);
    wait_outputs(ok);
    ready_pct = 100;
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].uid !== exp_q[i].uid) begin
        miscompares++;
        $display("FAIL random_beat %0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].data,
                 obs_q[i].last, obs_q[i].uid, exp_q[i].data, exp_q[i].last, exp_q[i].uid);
      end
    end
    vectors += 2;
    if (err_cnt != exp_err) begin
      miscompares++; $display("FAIL random_err_len: got %0d want %0d", err_cnt, exp_err);
    end
    if (stab_viol != 0) begin
      miscompares++; $display("FAIL random_stall_stable: got %0d changes want 0", stab_viol);
    end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    time t0;
    int  cycles;
    clear_scoreboard();
    ready_pct = 100;
    for (int p = 0; p < 10; p++) build_packet(OP_WRITEREQ, 1, 3);
    t0 = $time;
    drive_all(0);
    cycles = int'(($time - t0) / 10);
    wait_outputs(ok);
    vectors++;
    if (cycles != 30) begin
      miscompares++; $display("FAIL b2b_throughput: got %0d cycles want 30", cycles);
    end
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        miscompares++;
        $display("FAIL b2b_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data,
                 obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_midpack();
    bit ok;
    clear_scoreboard();
    ready_pct = 100;
    build_packet(OP_WRITEREQ, 20, 22);
    // Stop right after the first full value beat (hdr0, hdr1, key, 8 values).
    while (stim_q.size() > 11) void'(stim_q.pop_back());
    drive_all(0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL midpack_reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_scoreboard();
    build_packet(OP_UVWRITE, 10, 12);
    drive_all(10);
    wait_outputs(ok);
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midpack_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].uid !== exp_q[i].uid) begin
        miscompares++;
        $display("FAIL midpack_beat %0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].data,
                 obs_q[i].last, obs_q[i].uid, exp_q[i].data, exp_q[i].last, exp_q[i].uid);
      end
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++; $display("FAIL midpack_err_len: got %0d want 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_writereq_l17();
    test_writereq_l4();
    test_zero_len();
    test_early_tlast();
    test_back_to_back();
    test_random_stall();
    test_reset_midpack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
